db4_interp: RTL and testbench
=============================

DB4_INTERP -- requirements
Module: db4_interp

Interface
REQ-001 The block SHALL have no module parameters; all constants SHALL come from package db4_pkg.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 x_in  input  8  signed two's-complement input sample at the half (coarse) rate.
REQ-005 x_valid  input  1  x_in is valid this cycle.
REQ-006 x_ready  output  1  block accepts x_in this cycle; an accept occurs when x_valid and x_ready are both high at a rising edge.
REQ-007 y_out  output  9  signed interpolated output at the full (clk) rate.
REQ-008 y_valid  output  1  y_out is valid; no downstream backpressure exists.
REQ-009 y_phase  output  1  0 = G0 (even) polyphase output, 1 = G1 (odd) polyphase output.

Function
REQ-010 The block SHALL be a 2x polyphase DB4 synthesis interpolator: G0 = 124*x[n] + 57*x[n-1], G1 = 214*x[n] - 33*x[n-1].
REQ-011 Products SHALL be formed with shifts and adds only (RAG style), with no multiply operator; the accumulator width SHALL be 17 bits signed.
REQ-012 y_out SHALL equal acc[16:8], i.e. an arithmetic shift right by 8 (floor).
REQ-013 FSM states: S_IDLE (x_ready=1), S_EVEN (x_ready=0), S_ODD (x_ready=1).
REQ-014 In S_IDLE: an accept SHALL move to S_EVEN; otherwise the block SHALL stay in S_IDLE with y_valid<=0.
REQ-015 Leaving S_EVEN: y_out<=G0, y_valid<=1, y_phase<=0, and the state SHALL move to S_ODD unconditionally.
REQ-016 Leaving S_ODD: y_out<=G1, y_valid<=1, y_phase<=1; an accept in the same cycle SHALL move to S_EVEN, otherwise to S_IDLE.
REQ-017 On accept, x_cur<=x_in and x_prev<=x_cur; the delay line SHALL NOT advance without an accept.
REQ-018 An accept in S_ODD SHALL NOT corrupt the G1 output being produced, which uses the pre-accept x_cur/x_prev.
REQ-019 Latency: accept at edge E -> G0 visible after E+1 -> G1 visible after E+2; sustained x_valid SHALL give one accept per 2 clk and y_valid continuously high.
REQ-020 x_valid asserted in S_EVEN SHALL be ignored (no accept, no state change due to it).

Reset
REQ-021 While reset_n is low: state=S_IDLE, x_cur=x_prev=0, y_out=0, y_valid=0, y_phase=0, and x_ready SHALL be forced to 0.
REQ-022 Reset asserted mid-operation SHALL abort any pending G0/G1 output; after release the first sample SHALL see x_prev=0.

Configuration
REQ-023 Macro DB4I_ROUND_EN: when defined, y_out SHALL be (acc+128)>>>8 (round half up); when undefined, y_out SHALL be acc>>>8 (truncate toward minus infinity); no overflow is possible in either mode.

Structure
REQ-024 Package db4_pkg SHALL hold C0=124, C1=214, C2=57, C3=-33, XW=8, AW=17, YW=9, and the FSM state enum.
REQ-025 One combinational sub-module db4_rag SHALL map one 8-bit sample to the 17-bit products 124x, 214x, 57x, 33x; db4_interp SHALL instantiate it once per delay-line tap.

Verification
REQ-026 Reset, then impulse x=64, then x=0 (streaming) -> y_out sequence 31, 53, 14, -9 (with DB4I_ROUND_EN: 31, 54, 14, -8).
REQ-027 Constant x=-128 streaming -> steady state y_out=-91 on both phases; x=127 -> steady state 89 on both phases.
REQ-028 x_valid held high from reset release -> x_ready toggles 1,0,1,0 after the first accept; y_valid stays 1 continuously from E+1 on; y_phase alternates 0,1.
REQ-029 x_valid dropped for 3 cycles after one accept -> G0, then G1, then y_valid=0 while in S_IDLE; the delay line stays unchanged until the next accept.
REQ-030 reset_n pulsed low while in S_EVEN -> y_valid=0 and x_ready=0 immediately (asynchronously); after release, x=64 -> 31, 53 (x_prev cleared).

Source files
------------

// File: rtl/db4_pkg.sv
// db4_pkg -- shared constants, FSM state type and output scaling for the
// DB4 2x polyphase synthesis interpolator.
//   XW/AW/YW    : sample, accumulator and output widths
//   C0..C3      : polyphase taps (G0 = C0*x[n] + C2*x[n-1],
//                                 G1 = C1*x[n] + C3*x[n-1])
//   db4_state_e : interpolator FSM states
//   db4_scale   : accumulator -> output scaling
// Build option: define DB4I_ROUND_EN to round half up instead of flooring.
package db4_pkg;

  localparam int XW = 8;
  localparam int AW = 17;
  localparam int YW = 9;

  localparam int C0 = 124;
  localparam int C1 = 214;
  localparam int C2 = 57;
  localparam int C3 = -33;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVEN = 2'd1,
    S_ODD  = 2'd2
  } db4_state_e;

  // Keep the top YW bits of the accumulator (arithmetic shift right by 8).
  // |acc| stays below 2^15 for any 8-bit input pair, so the +128 bias
  // cannot overflow AW bits.
  function automatic logic signed [YW-1:0] db4_scale(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] t;
`ifdef DB4I_ROUND_EN
    t = acc + AW'(128);
`else
    t = acc;
`endif
    return t[AW-1:AW-YW];
  endfunction

endpackage

// File: rtl/db4_rag.sv
// db4_rag -- combinational shift/add product generator for one delay-line
// tap of the DB4 interpolator.
//   x    : signed XW-bit sample
//   p124 : 124*x   p214 : 214*x   p57 : 57*x   p33 : 33*x  (signed AW-bit)
// Build option: none (DB4I_ROUND_EN is handled in db4_pkg::db4_scale).
module db4_rag
  import db4_pkg::*;
(
  input  logic signed [XW-1:0] x,
  output logic signed [AW-1:0] p124,
  output logic signed [AW-1:0] p214,
  output logic signed [AW-1:0] p57,
  output logic signed [AW-1:0] p33
);

  logic signed [AW-1:0] xe;

  assign xe = {{(AW-XW){x[XW-1]}}, x};

  // 124 = 128 - 4
  assign p124 = (xe <<< 7) - (xe <<< 2);
  // 214 = 256 - 32 - 8 - 2
  assign p214 = (xe <<< 8) - (xe <<< 5) - (xe <<< 3) - (xe <<< 1);
  // 57 = 64 - 8 + 1
  assign p57  = (xe <<< 6) - (xe <<< 3) + xe;
  // 33 = 32 + 1
  assign p33  = (xe <<< 5) + xe;

endmodule

// File: rtl/db4_interp.sv
// db4_interp -- 2x polyphase DB4 synthesis interpolator.
//   clk     : clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   x_in    : signed 8-bit coarse-rate sample, x_valid qualifies it
//   x_ready : sample accepted when x_valid && x_ready at a rising edge
//   y_out   : signed 9-bit full-rate output, y_valid qualifies it
//   y_phase : 0 = G0 (even) output, 1 = G1 (odd) output
// Build option: DB4I_ROUND_EN selects round-half-up output scaling.
module db4_interp
  import db4_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [XW-1:0] x_in,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic signed [YW-1:0] y_out,
  output logic                 y_valid,
  output logic                 y_phase
);

  db4_state_e           state;
  logic signed [XW-1:0] x_cur;
  logic signed [XW-1:0] x_prev;
  logic signed [AW-1:0] cur_124, cur_214, cur_57, cur_33;
  logic signed [AW-1:0] prv_124, prv_214, prv_57, prv_33;
  logic signed [AW-1:0] g0, g1;
  logic                 accept;
  logic                 unused_taps;

  db4_rag u_rag_cur (
    .x    (x_cur),
    .p124 (cur_124),
    .p214 (cur_214),
    .p57  (cur_57),
    .p33  (cur_33)
  );

  db4_rag u_rag_prev (
    .x    (x_prev),
    .p124 (prv_124),
    .p214 (prv_214),
    .p57  (prv_57),
    .p33  (prv_33)
  );

  // Each tap only needs two of its four products.
  assign unused_taps = ^{cur_57, cur_33, prv_124, prv_214};

  assign g0 = cur_124 + prv_57;
  assign g1 = cur_214 - prv_33;

  assign x_ready = reset_n && (state != S_EVEN);
  assign accept  = x_valid && x_ready;

  // G1 is computed from the registered taps, so a sample accepted in S_ODD
  // only reaches the products one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      x_cur   <= '0;
      x_prev  <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      y_phase <= 1'b0;
    end else begin
      if (accept) begin
        x_cur  <= x_in;
        x_prev <= x_cur;
      end
      case (state)
        S_IDLE: begin
          y_valid <= 1'b0;
          if (accept) state <= S_EVEN;
        end
        S_EVEN: begin
          y_out   <= db4_scale(g0);
          y_valid <= 1'b1;
          y_phase <= 1'b0;
          state   <= S_ODD;
        end
        S_ODD: begin
          y_out   <= db4_scale(g1);
          y_valid <= 1'b1;
          y_phase <= 1'b1;
          state   <= accept ? S_EVEN : S_IDLE;
        end
        default: begin
          y_valid <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_db4_interp.sv
// tb_db4_interp -- scoreboard bench for db4_interp.
// Expected outputs are computed with integer multiplies from the tap values
// and queued with the cycle in which they must appear.
module tb_db4_interp;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic signed [7:0] x_in = '0;
  logic              x_valid = 1'b0;
  logic              x_ready;
  logic signed [8:0] y_out;
  logic              y_valid;
  logic              y_phase;

  db4_interp dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x_in    (x_in),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .y_out   (y_out),
    .y_valid (y_valid),
    .y_phase (y_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic signed [8:0] y;
    logic              ph;
  } exp_t;

  exp_t sb[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc = -100;
  int   m_cur    = 0;
  int   m_prev   = 0;

  function automatic logic signed [8:0] model(input int acc);
    int a;
    a = acc;
`ifdef DB4I_ROUND_EN
    a = a + 128;
`endif
    return 9'(a >>> 8);
  endfunction

  task automatic clear_model();
    sb.delete();
    m_cur    = 0;
    m_prev   = 0;
    last_acc = -100;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    x_valid = 1'b0;
    x_in    = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // One clock: drive inputs, check x_ready, advance, check outputs.
  task automatic step(input logic v, input logic signed [7:0] x);
    logic exp_ready;
    exp_t e;
    x_valid   = v;
    x_in      = x;
    exp_ready = (last_acc != cyc);
    #1;
    n_chk++;
    if (x_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL x_ready cyc=%0d got %b want %b", cyc, x_ready, exp_ready);
    end
    @(posedge clk);
    cyc++;
    if (v && exp_ready) begin
      last_acc = cyc;
      m_prev   = m_cur;
      m_cur    = int'(x);
      sb.push_back('{cyc + 1, model(124 * m_cur + 57 * m_prev), 1'b0});
      sb.push_back('{cyc + 2, model(214 * m_cur - 33 * m_prev), 1'b1});
    end
    #1;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (y_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL y_valid cyc=%0d got %b want 1", cyc, y_valid);
      end
      n_chk++;
      if (y_out !== e.y) begin
        n_fail++;
        $display("FAIL y_out cyc=%0d got %0d want %0d", cyc, y_out, e.y);
      end
      n_chk++;
      if (y_phase !== e.ph) begin
        n_fail++;
        $display("FAIL y_phase cyc=%0d got %b want %b", cyc, y_phase, e.ph);
      end
    end else begin
      n_chk++;
      if (y_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL y_valid_idle cyc=%0d got %b want 0", cyc, y_valid);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    reset_n = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    n_chk++;
    if (x_ready !== 1'b0 || y_valid !== 1'b0 || y_out !== 9'sd0 || y_phase !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b y=%0d ph=%b want 0,0,0,0",
               x_ready, y_valid, y_out, y_phase);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_impulse();
    logic signed [8:0] imp [4];
`ifdef DB4I_ROUND_EN
    imp[0] = 9'sd31; imp[1] = 9'sd54; imp[2] = 9'sd14; imp[3] = -9'sd8;
`else
    imp[0] = 9'sd31; imp[1] = 9'sd53; imp[2] = 9'sd14; imp[3] = -9'sd9;
`endif
    apply_reset();
    step(1'b1, 8'sd64);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'sd0);
      n_chk++;
      if (y_out !== imp[i]) begin
        n_fail++;
        $display("FAIL impulse[%0d] got %0d want %0d", i, y_out, imp[i]);
      end
    end
  endtask

  task automatic test_const(input logic signed [7:0] c, input logic signed [8:0] want);
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, c);
      if (i >= 6) begin
        n_chk++;
        if (y_out !== want) begin
          n_fail++;
          $display("FAIL const_%0d step%0d got %0d want %0d", c, i, y_out, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 24; i++) step(1'b1, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_gap();
    apply_reset();
    step(1'b1, 8'sd50);
    repeat (3) step(1'b0, 8'sd0);
    step(1'b1, -8'sd20);
    repeat (3) step(1'b0, 8'sd77);
    step(1'b1, 8'sd127);
    step(1'b0, 8'sd0);
    step(1'b1, -8'sd128);
    repeat (3) step(1'b0, 8'sd0);
  endtask

  task automatic test_reset_mid();
    logic signed [8:0] w0, w1;
`ifdef DB4I_ROUND_EN
    w0 = 9'sd31; w1 = 9'sd54;
`else
    w0 = 9'sd31; w1 = 9'sd53;
`endif
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'sd100);
    // Five streamed steps end on an accept from S_ODD: now in S_EVEN, y_valid high.
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (y_valid !== 1'b0 || x_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got vld=%b rdy=%b want 0,0", y_valid, x_ready);
    end
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, 8'sd64);
    step(1'b1, 8'sd0);
    n_chk++;
    if (y_out !== w0) begin
      n_fail++;
      $display("FAIL post_reset_g0 got %0d want %0d", y_out, w0);
    end
    step(1'b1, 8'sd0);
    n_chk++;
    if (y_out !== w1) begin
      n_fail++;
      $display("FAIL post_reset_g1 got %0d want %0d", y_out, w1);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
`ifdef DB4I_ROUND_EN
    test_const(-8'sd128, -9'sd90);
    test_const(8'sd127, 9'sd90);
`else
    test_const(-8'sd128, -9'sd91);
    test_const(8'sd127, 9'sd89);
`endif
    test_back_to_back();
    test_gap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
